alu_result_writeback: RTL and testbench

- Downstream stage of the 16-lane ALU.
- Captures one full ALU result set (per-lane low word C and high word D, together forming a signed 64-bit result) on a valid/ready handshake.
- Serializes that result into a 32-bit-wide result memory, one word per accepted beat.
- Frees the ALU to start the next operation while writeback proceeds.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_result_writeback.sv | 142 ++++++++++++++
 tb/tb_alu_result_writeback.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU types, lane geometry and op encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int LANES = 16;
  localparam int WIDTH = 32;

  typedef logic [WIDTH-1:0] word_t;
  typedef word_t [LANES-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_result_writeback.sv
// ============================================================================
// Module  : alu_result_writeback
// Brief   : Captures a 16-lane ALU result set and serializes it into a 32-bit
//           result memory. Optional macro WB_COMPACT_ADD_EN: add sets write
//           only the low words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_writeback #(
  parameter int LANES  = alu_pkg::LANES,
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] res_lo,
  input  logic [LANES*WIDTH-1:0] res_hi,
  input  logic                   res_op,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic                   mem_ready,
  output logic                   done
);

  import alu_pkg::*;

  localparam int BW = $clog2(2*LANES);

  wb_state_t              state;
  wb_state_t              state_next;
  logic [BW-1:0]          beat;
  logic [BW-1:0]          last_beat;
  logic [BW-1:0]          lane_idx;
  logic                   sel_hi;
  logic [LANES*WIDTH-1:0] lo_q;
  logic [LANES*WIDTH-1:0] hi_q;
  logic [ADDR_W-1:0]      base_q;
  logic                   accept;
  logic                   beat_taken;

  assign accept     = in_valid && in_ready;
  assign beat_taken = mem_we && mem_ready;

`ifdef WB_COMPACT_ADD_EN
  logic op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADD;
    end else if (accept) begin
      op_q <= res_op;
    end
  end

  // Add sets carry no meaningful high word, so one beat per lane suffices.
  always_comb begin
    if (op_q == OP_ADD) begin
      last_beat = BW'(LANES-1);
      lane_idx  = beat;
      sel_hi    = 1'b0;
    end else begin
      last_beat = BW'(2*LANES-1);
      lane_idx  = beat >> 1;
      sel_hi    = beat[0];
    end
  end
`else
  logic unused_op;
  assign unused_op = res_op;

  always_comb begin
    last_beat = BW'(2*LANES-1);
    lane_idx  = beat >> 1;
    sel_hi    = beat[0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // Held low while reset is asserted even though the state reads IDLE.
        in_ready = rst_n;
        if (accept) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (beat_taken && (beat == last_beat)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      base_q <= '0;
      beat   <= '0;
    end else if (accept) begin
      lo_q   <= res_lo;
      hi_q   <= res_hi;
      base_q <= base_addr;
      beat   <= '0;
    end else if (beat_taken && (beat != last_beat)) begin
      beat <= beat + 1'b1;
    end
  end

  assign mem_addr  = base_q + ADDR_W'(beat);
  assign mem_wdata = sel_hi ? hi_q[lane_idx*WIDTH +: WIDTH]
                            : lo_q[lane_idx*WIDTH +: WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_alu_result_writeback.sv
// ============================================================================
// Module  : tb_alu_result_writeback
// Brief   : Directed self-checking bench for alu_result_writeback.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_writeback;

  localparam int LANES  = 16;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] res_lo = '0;
  logic [LANES*WIDTH-1:0] res_hi = '0;
  logic                   res_op = 1'b0;
  logic [ADDR_W-1:0]      base_addr = '0;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [WIDTH-1:0]       mem_wdata;
  logic                   mem_ready = 1'b0;
  logic                   done;

  int errors = 0;
  int checks = 0;

  logic [31:0] lo_v [LANES];
  logic [31:0] hi_v [LANES];

  alu_result_writeback #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .res_lo   (res_lo),
    .res_hi   (res_hi),
    .res_op   (res_op),
    .base_addr(base_addr),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_beats(input logic op);
`ifdef WB_COMPACT_ADD_EN
    if (op == 1'b0) return LANES;
`endif
    return 2*LANES;
  endfunction

  function automatic logic [31:0] exp_word(input int k, input logic op);
`ifdef WB_COMPACT_ADD_EN
    if (op == 1'b0) return lo_v[k];
`endif
    return (k % 2 == 1) ? hi_v[k/2] : lo_v[k/2];
  endfunction

  // mode 0: mem_ready always high; mode 1: ready pattern 1,0,0 repeating.
  // abort_at >= 0 asserts reset while that beat is on the bus.
  task automatic run_set(input logic [7:0] base, input logic op, input int mode,
                         input int abort_at, input bit hold_valid);
    int  k;
    int  c;
    int  nb;
    bit  fin;
    bit  aborted;
    logic [7:0] ea;
    nb = n_beats(op);
    for (int i = 0; i < LANES; i++) begin
      res_lo[i*WIDTH +: WIDTH] = lo_v[i];
      res_hi[i*WIDTH +: WIDTH] = hi_v[i];
    end
    res_op    = op;
    base_addr = base;
    in_valid  = 1'b1;
    check("ready_before_hs", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid  = hold_valid;
    res_lo    = {LANES{32'hDEAD_BEEF}};
    res_hi    = {LANES{32'h0BAD_F00D}};
    res_op    = ~op;
    base_addr = ~base;
    k = 0; c = 1; fin = 0; aborted = 0;
    while (!fin && c < 300) begin
      mem_ready = (mode == 0) ? 1'b1 : (c % 3 == 1);
      if (c == 6) in_valid = 1'b0;
      if (abort_at >= 0 && k == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_we", {63'd0, mem_we}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        check("abort_no_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("abort_idle_ready", {63'd0, in_ready}, 64'd1);
        fin = 1; aborted = 1;
      end else if (k < nb) begin
        ea = base + 8'(k);
        check("we", {63'd0, mem_we}, 64'd1);
        check("addr", {56'd0, mem_addr}, {56'd0, ea});
        check("data", {32'd0, mem_wdata}, {32'd0, exp_word(k, op)});
        check("done_early", {63'd0, done}, 64'd0);
        check("ready_busy", {63'd0, in_ready}, 64'd0);
        if (mem_ready) k++;
        @(posedge clk); #1;
        c++;
      end else begin
        check("done_pulse", {63'd0, done}, 64'd1);
        check("we_in_done", {63'd0, mem_we}, 64'd0);
        check("ready_in_done", {63'd0, in_ready}, 64'd0);
        if (mode == 0) check("done_cycle", 64'(c), 64'(nb + 1));
        fin = 1;
        @(posedge clk); #1;
      end
    end
    if (!fin) begin
      check("timeout", 64'd0, 64'd1);
    end else if (!aborted) begin
      check("ready_after", {63'd0, in_ready}, 64'd1);
      check("done_once", {63'd0, done}, 64'd0);
    end
    mem_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    #2;
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    check("rst_we", {63'd0, mem_we}, 64'd0);
    check("rst_addr", {56'd0, mem_addr}, 64'd0);
    check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_ready", {63'd0, in_ready}, 64'd1);
      check("idle_we", {63'd0, mem_we}, 64'd0);
      check("idle_done", {63'd0, done}, 64'd0);
    end
    mem_ready = 1'b0;

    for (int i = 0; i < LANES; i++) begin
      lo_v[i] = 32'(i);
      hi_v[i] = 32'hFFFF_FFFF;
    end
    run_set(8'h10, 1'b1, 0, -1, 1'b0);

    for (int i = 0; i < LANES; i++) begin
      lo_v[i] = 32'hA000_0000 + 32'(i);
      hi_v[i] = 32'h5000_0000 + 32'(i * 3);
    end
    run_set(8'h40, 1'b1, 1, -1, 1'b0);

    for (int i = 0; i < LANES; i++) begin
      lo_v[i] = 32'h1234_0000 + 32'(i << 4);
      hi_v[i] = 32'h8765_0000 - 32'(i);
    end
    run_set(8'hF0, 1'b1, 0, -1, 1'b1);

    run_set(8'h80, 1'b1, 0, 5, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < LANES; i++) begin
      lo_v[i] = 32'hC0DE_0000 | 32'(i);
      hi_v[i] = 32'h0000_FACE ^ 32'(i << 20);
    end
    run_set(8'h20, 1'b1, 0, -1, 1'b0);

    run_set(8'h00, 1'b0, 0, -1, 1'b0);
    run_set(8'h00, 1'b1, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
